// File: rtl/exe_div.sv
`default_nettype none
// ============================================================================
// Module   : exe_div
// Purpose  : Iterative RV32M divide unit (DIV/DIVU/REM/REMU) in the execute
//            stage. Restoring radix-2 division, one quotient bit per cycle.
//            The unit requests a pipeline stall while it works and emits a
//            one-cycle writeback strobe with the result.
// Ports    : clk_i           clock
//            rst_i           synchronous active-high reset
//            inst_i          instruction held in ID/EXE
//            op1_i / op2_i   dividend (rs1) / divisor (rs2)
//            reg_waddr_i     destination register from ID/EXE
//            flush_jump_i    pipeline flush; aborts any operation
//            stall_req_o     stall request to ctrl (issue cycle and BUSY)
//            busy_o          unit not idle
//            result_o        quotient or remainder (valid with strobe)
//            result_valid_o  one-cycle result strobe
//            reg_we_o        register write enable (same as result_valid_o)
//            reg_waddr_o     destination register captured at issue
// Options  : DIV_EARLY_TERM_EN - when defined, operands with |op1| < |op2|
//            (nonzero divisor) finish in one cycle with quotient 0.
// Revision : 1.0 - initial release
// ============================================================================
module exe_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      reg_waddr_i,
    input  logic            flush_jump_i,
    output logic            stall_req_o,
    output logic            busy_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o,
    output logic            reg_we_o,
    output logic [4:0]      reg_waddr_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0]      c_IDLE   = 2'd0;
    localparam logic [1:0]      c_BUSY   = 2'd1;
    localparam logic [1:0]      c_DONE   = 2'd2;

    localparam logic [6:0]      c_OPCODE = 7'b0110011;
    localparam logic [6:0]      c_FUNCT7 = 7'b0000001;

    localparam logic [CNT_W-1:0] c_ITER  = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    localparam logic [XLEN-1:0] c_ZERO   = '0;
    localparam logic [XLEN-1:0] c_ONES   = '1;
    localparam logic [XLEN-1:0] c_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [1:0]       r_fn;        // {rem_select, unsigned} = funct3[1:0]
    logic [4:0]       r_waddr;
    logic [XLEN-1:0]  r_quot;      // dividend shifts out, quotient shifts in
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_divisor;
    logic [CNT_W-1:0] r_count;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_special;   // result preloaded, skip sign correction
    logic [XLEN-1:0]  r_result;

    // ------------------------------------------------------------------
    // Decode and start
    // ------------------------------------------------------------------
    logic            w_is_div;
    logic            w_start;
    logic            w_signed;
    logic            w_s1;
    logic            w_s2;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic            w_div0;
    logic            w_ovf;
    logic            w_early;
    logic            w_special;

    assign w_is_div = (inst_i[6:0] == c_OPCODE) &&
                      (inst_i[31:25] == c_FUNCT7) &&
                      inst_i[14];
    assign w_start  = w_is_div && (r_state == c_IDLE) && !flush_jump_i && !rst_i;

    // funct3[0] clear selects the signed variants (DIV/REM)
    assign w_signed = !inst_i[12];
    assign w_s1     = w_signed && op1_i[XLEN-1];
    assign w_s2     = w_signed && op2_i[XLEN-1];
    assign w_abs1   = w_s1 ? (c_ZERO - op1_i) : op1_i;
    assign w_abs2   = w_s2 ? (c_ZERO - op2_i) : op2_i;

    assign w_div0   = (op2_i == c_ZERO);
    assign w_ovf    = w_signed && (op1_i == c_MIN) && (op2_i == c_ONES);

`ifdef DIV_EARLY_TERM_EN
    assign w_early  = (w_abs1 < w_abs2) && !w_div0;
`else
    assign w_early  = 1'b0;
`endif

    assign w_special = w_div0 || w_ovf || w_early;

    // ------------------------------------------------------------------
    // One restoring step. The shifted remainder needs XLEN+1 bits for the
    // compare; when the subtraction is taken the difference is below the
    // divisor, so the low XLEN bits of a modular subtract are exact.
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_diff;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quot_next;

    assign w_rem_sh    = {r_rem, r_quot[XLEN-1]};
    assign w_ge        = (w_rem_sh >= {1'b0, r_divisor});
    assign w_rem_diff  = w_rem_sh[XLEN-1:0] - r_divisor;
    assign w_rem_next  = w_ge ? w_rem_diff : w_rem_sh[XLEN-1:0];
    assign w_quot_next = {r_quot[XLEN-2:0], w_ge};

    // ------------------------------------------------------------------
    // Sign correction and result select (applied in DONE)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_quot_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_final;
    logic            w_valid;

    assign w_quot_fix = (r_q_neg && !r_special) ? (c_ZERO - r_quot) : r_quot;
    assign w_rem_fix  = (r_r_neg && !r_special) ? (c_ZERO - r_rem)  : r_rem;
    assign w_final    = r_fn[1] ? w_rem_fix : w_quot_fix;

    // A flush in DONE cancels the writeback
    assign w_valid    = (r_state == c_DONE) && !flush_jump_i && !rst_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_state_next = w_special ? c_DONE : c_BUSY;
                end
            end
            c_BUSY: begin
                if (r_count == c_ONE) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                // Always return to IDLE; never restarts on the same inst
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
        if (flush_jump_i) begin
            w_state_next = c_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= c_IDLE;
            r_fn      <= 2'b00;
            r_waddr   <= 5'd0;
            r_quot    <= c_ZERO;
            r_rem     <= c_ZERO;
            r_divisor <= c_ZERO;
            r_count   <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_special <= 1'b0;
            r_result  <= c_ZERO;
        end else begin
            r_state <= w_state_next;

            if (w_start) begin
                r_fn      <= inst_i[13:12];
                r_waddr   <= reg_waddr_i;
                r_divisor <= w_abs2;
                r_count   <= c_ITER;
                r_q_neg   <= w_s1 ^ w_s2;
                r_r_neg   <= w_s1;
                r_special <= w_special;
                // Special cases preload the final quotient/remainder
                if (w_div0) begin
                    r_quot <= c_ONES;
                    r_rem  <= op1_i;
                end else if (w_ovf) begin
                    r_quot <= c_MIN;
                    r_rem  <= c_ZERO;
                end else if (w_early) begin
                    r_quot <= c_ZERO;
                    r_rem  <= op1_i;
                end else begin
                    r_quot <= w_abs1;
                    r_rem  <= c_ZERO;
                end
            end else if (r_state == c_BUSY) begin
                r_quot  <= w_quot_next;
                r_rem   <= w_rem_next;
                r_count <= r_count - c_ONE;
            end

            if (w_valid) begin
                r_result <= w_final;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall_req_o    = !rst_i && !flush_jump_i &&
                            (w_start || (r_state == c_BUSY));
    assign busy_o         = (r_state != c_IDLE);
    assign result_o       = w_valid ? w_final : r_result;
    assign result_valid_o = w_valid;
    assign reg_we_o       = w_valid;
    assign reg_waddr_o    = r_waddr;

endmodule
`default_nettype wire
